// File: rtl/if_id_buffer_pkg.sv
// Shared widths, entry layout and reset-time constants for the fetch-to-decode buffer.
package if_id_buffer_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned PC_W    = 16;
    localparam int unsigned ENTRY_W = INSTR_W + PC_W + 1;

    localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = 16'h0800;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    incPC;
        logic               err;
    } entry_t;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/if_id_entry.sv
// One buffered fetch slot: {instr, incPC, err} held until overwritten by a write.
module if_id_entry
    import if_id_buffer_pkg::*;
(
    input  logic   clk,
    input  logic   i_we,
    input  entry_t i_data,
    output entry_t o_data
);

    entry_t r_data;

    // Contents need no reset: occupancy alone decides whether a slot is visible.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_data <= i_data;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: small in-order queue between fetch and decode with flush-to-NOP.
module if_id_buffer
    import if_id_buffer_pkg::*;
#(
    parameter int unsigned        DEPTH     = 2,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT,
    localparam int unsigned       PTR_W     = ptr_width(DEPTH),
    localparam int unsigned       CNT_W     = PTR_W + 1
)(
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_incPC,
    input  logic               in_err,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_incPC,
    output logic               out_err,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   count
);

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             w_push;
    logic             w_pop;
    logic [DEPTH-1:0] w_we;
    entry_t           w_wdata;
    entry_t           w_head_entry;
    entry_t           w_entries [DEPTH];

    // in_ready looks only at registered occupancy so fetch never sees out_ready combinationally.
    assign in_ready  = rst && (r_count < CNT_W'(DEPTH));
    assign out_valid = (r_count != '0) && !flush;
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready;
    assign count     = r_count;

    assign w_wdata = '{instr: in_instr, incPC: in_incPC, err: in_err};

    always_comb begin
        w_we = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_we[i] = w_push && (r_tail == PTR_W'(i));
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        if_id_entry u_entry (
            .clk    (clk),
            .i_we   (w_we[g]),
            .i_data (w_wdata),
            .o_data (w_entries[g])
        );
    end

    assign w_head_entry = w_entries[r_head];

    always_comb begin
        out_instr = NOP_INSTR;
        out_incPC = '0;
        out_err   = 1'b0;
        if (out_valid) begin
            out_instr = w_head_entry.instr;
            out_incPC = w_head_entry.incPC;
            out_err   = w_head_entry.err;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer: reset, streaming, stall-to-full, flush, wrap, err carry.
module tb_if_id_buffer;

    logic        clk;
    logic        rst;
    logic [15:0] in_instr;
    logic [15:0] in_incPC;
    logic        in_err;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [15:0] out_instr;
    logic [15:0] out_incPC;
    logic        out_err;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  count;

    int unsigned n_checks;
    int unsigned n_errors;

    if_id_buffer #(
        .DEPTH     (2),
        .NOP_INSTR (16'h0800)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_instr  (in_instr),
        .in_incPC  (in_incPC),
        .in_err    (in_err),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_instr (out_instr),
        .out_incPC (out_incPC),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 16'hC0FF;
        in_incPC  = 16'h1234;
        in_err    = 1'b1;
        out_ready = 1'b0;

        // Reset held two cycles with fetch trying to push
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_instr", 32'(out_instr), 32'h0800);
        check("rst_out_incPC", 32'(out_incPC), 32'h0);
        check("rst_out_err",   32'(out_err),   32'h0);
        check("rst_count",     32'(count),     32'h0);
        check("rst_in_ready",  32'(in_ready),  32'h0);
        rst      = 1'b1;
        in_valid = 1'b0;
        in_err   = 1'b0;
        settle();
        check("rel_in_ready",  32'(in_ready),  32'h1);
        step();
        check("rel_count",     32'(count),     32'h0);

        // Streaming with decode always ready
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 16'h4001;
        in_incPC  = 16'h0002;
        settle();
        check("str_no_bypass", 32'(out_valid), 32'h0);
        step();
        in_instr = 16'h4002;
        in_incPC = 16'h0004;
        settle();
        check("str1_valid", 32'(out_valid), 32'h1);
        check("str1_instr", 32'(out_instr), 32'h4001);
        check("str1_pc",    32'(out_incPC), 32'h0002);
        check("str1_count", 32'(count),     32'h1);
        step();
        in_valid = 1'b0;
        settle();
        check("str2_instr", 32'(out_instr), 32'h4002);
        check("str2_pc",    32'(out_incPC), 32'h0004);
        check("str2_count", 32'(count),     32'h1);
        step();
        check("str_drain_valid", 32'(out_valid), 32'h0);
        check("str_drain_instr", 32'(out_instr), 32'h0800);

        // Stall until full; third push must be refused
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 16'hA001;
        in_incPC  = 16'h0010;
        step();
        in_instr = 16'hA002;
        in_incPC = 16'h0012;
        step();
        in_instr = 16'hA003;
        in_incPC = 16'h0014;
        settle();
        check("full_count",    32'(count),    32'h2);
        check("full_in_ready", 32'(in_ready), 32'h0);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        settle();
        check("full_hold_count", 32'(count),     32'h2);
        check("full_head",       32'(out_instr), 32'h0000A001);
        check("full_pop_ready",  32'(in_ready),  32'h0);
        step();
        check("pop1_instr",    32'(out_instr), 32'h0000A002);
        check("pop1_in_ready", 32'(in_ready),  32'h1);
        check("pop1_count",    32'(count),     32'h1);
        step();
        check("pop2_valid", 32'(out_valid), 32'h0);
        check("pop2_count", 32'(count),     32'h0);

        // Flush while full, with a competing push
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 16'hB001;
        step();
        in_instr = 16'hB002;
        step();
        check("pre_flush_count", 32'(count), 32'h2);
        flush    = 1'b1;
        in_instr = 16'hBEEF;
        settle();
        check("flush_valid", 32'(out_valid), 32'h0);
        check("flush_instr", 32'(out_instr), 32'h0800);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        settle();
        check("post_flush_count", 32'(count),     32'h0);
        check("post_flush_instr", 32'(out_instr), 32'h0800);
        check("post_flush_valid", 32'(out_valid), 32'h0);
        step();
        check("beef_not_stored", 32'(count), 32'h0);

        // Wrap-around: push two, pop one repeatedly so pointers cross DEPTH-1 twice
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            in_instr  = 16'h1000 + 16'(i);
            in_incPC  = 16'h0100 + 16'(2 * i);
            out_ready = 1'b0;
            step();
            in_valid = 1'b0;
            settle();
            check("wrap_instr", 32'(out_instr), 32'h1000 + 32'(i));
            check("wrap_pc",    32'(out_incPC), 32'h0100 + 32'(2 * i));
            check("wrap_count", 32'(count),     32'h1);
            out_ready = 1'b1;
            step();
            check("wrap_empty", 32'(count), 32'h0);
        end
        out_ready = 1'b0;

        // Error flag follows its own entry only
        in_valid = 1'b1;
        in_instr = 16'h2222;
        in_err   = 1'b1;
        step();
        in_instr = 16'h3333;
        in_err   = 1'b0;
        settle();
        check("err_head_instr", 32'(out_instr), 32'h2222);
        check("err_head_err",   32'(out_err),   32'h1);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        settle();
        check("err_two_count", 32'(count),   32'h2);
        check("err_still_set", 32'(out_err), 32'h1);
        step();
        out_ready = 1'b0;
        settle();
        check("err_next_instr", 32'(out_instr), 32'h3333);
        check("err_next_err",   32'(out_err),   32'h0);
        check("err_one_count",  32'(count),     32'h1);

        // Mid-run reset with one entry held, plus flush to prove reset dominates
        rst   = 1'b0;
        flush = 1'b1;
        step();
        rst   = 1'b1;
        flush = 1'b0;
        settle();
        check("mid_rst_count", 32'(count),     32'h0);
        check("mid_rst_err",   32'(out_err),   32'h0);
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        check("mid_rst_ready", 32'(in_ready),  32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
- Fetch-to-decode pipeline buffer sitting directly downstream of the fetch stage.
- Captures {instruction, incPC, err} when fetch asserts instruction-valid, and presents them to decode under a valid/ready handshake.
- A small in-order queue absorbs decode stalls without dropping or duplicating an instruction.
- Branch misprediction or jump flushes all buffered entries and presents NOP (16'h0800) to decode.

Parameters:
- DEPTH, 2, number of buffered entries (power of two, >= 2).
- NOP_INSTR, 16'h0800, instruction word presented to decode when no valid entry exists.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- in_instr  input  16  instruction word from fetch.
- in_incPC  input  16  PC+2 from fetch.
- in_err  input  1  fetch error flag.
- in_valid  input  1  fetch has a valid instruction this cycle.
- in_ready  output  1  buffer can accept; 1 when count < DEPTH and rst is high.
- flush  input  1  jump in execute OR branch misprediction; squashes all entries.
- out_instr  output  16  head instruction; NOP_INSTR when out_valid = 0.
- out_incPC  output  16  head PC+2; 16'h0000 when out_valid = 0.
- out_err  output  1  head error flag; 0 when out_valid = 0.
- out_valid  output  1  head entry valid.
- out_ready  input  1  decode consumes the head this cycle (deasserted on decode stall).
- count  output  log2(DEPTH)+1  current occupancy.

Behaviour:
- State:
  - DEPTH entries of {instr[15:0], incPC[15:0], err}.
  - Head pointer and tail pointer, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - count register.
- Reset (rst = 0 at a rising edge): pointers = 0, count = 0. Entry contents are don't-care.
- Outputs after reset: out_valid = 0, out_instr = NOP_INSTR, out_incPC = 0, out_err = 0, in_ready = 0 while rst = 0, then 1.
- Handshake definitions:
  - push = in_valid & in_ready & ~flush.
  - pop = out_valid & out_ready.
- Visibility: out_valid = (count != 0) & ~flush. This is combinational gating, so a flushed head is never seen as valid in the flush cycle.
- Output fields are combinational from entry[head], muxed to NOP/zero when out_valid = 0.
- Latency: an instruction pushed at edge N is visible at the outputs after edge N, i.e. one cycle. There is no combinational bypass from in_* to out_*.
- in_ready depends only on registered count (and rst), never on out_ready. This avoids a comb loop into fetch's PC write-enable.
- Next-state priority:
  1. Reset.
  2. flush: count = 0, head = tail = 0; push and pop are ignored.
  3. push and pop together: write at tail, tail += 1, head += 1, count unchanged.
  4. push only: write at tail, tail += 1, count += 1.
  5. pop only: head += 1, count -= 1.
  6. Neither: hold.
- Full (count = DEPTH): in_ready = 0; in_valid is ignored and fetch holds its PC. At full with pop, a slot frees but in_ready rises only in the next cycle.
- Empty (count = 0): out_valid = 0 and NOP is presented; out_ready is ignored.
- Wrap-around: pointers roll from DEPTH-1 to 0; ordering is strictly FIFO.
- Flush while full, empty, or mid-stall: all entries are discarded. Fetch's redirected instruction may be pushed starting the cycle after flush.
- Reset mid-operation: contents are discarded identically to flush. Reset overrides flush.
- err is carried per entry; no sticky behaviour.
- in_* fields are captured only on push; held values otherwise have no effect.

Decomposition:
- Shared package/include:
  - NOP_INSTR = 16'h0800.
  - Pointer and count widths derived from DEPTH.
  - Entry field widths (INSTR_W = 16, PC_W = 16).
- One natural sub-module: if_id_entry, a single 33-bit storage slot with write-enable.
  - Built from the codebase's existing dff cells.
  - Instantiated DEPTH times.
- Pointer/count logic and output muxing live in the top.

Test Plan:
- Reset:
  - Stimulus: hold rst = 0 for 2 cycles with in_valid = 1, in_instr = 16'hC0FF.
  - Required: out_valid = 0, out_instr = 16'h0800, count = 0, in_ready = 0.
  - After release: in_ready = 1.
- Streaming:
  - Stimulus: out_ready = 1, push 16'h4001/incPC 16'h0002, then 16'h4002/16'h0004 on consecutive cycles.
  - Required: each appears one cycle later in order, count stays at 1.
- Stall to full:
  - Stimulus: out_ready = 0, push 16'hA001, 16'hA002, 16'hA003.
  - Required: count = 2, in_ready = 0 on the third push so 16'hA003 is not accepted.
  - Then out_ready = 1: 16'hA001, 16'hA002 emerge in order; in_ready returns 1 one cycle after the first pop.
- Flush while full:
  - Stimulus: with 2 entries held, assert flush together with in_valid = 1 (16'hBEEF).
  - Required: out_valid = 0 in that cycle; next cycle count = 0, out_instr = 16'h0800, 16'hBEEF not stored.
- Wrap-around:
  - Stimulus: push/pop 5 instructions (16'h1000..16'h1004) alternating stalls so the pointers wrap twice.
  - Required: output order is exact, no duplicate or lost word.
- Error carry and mid-run reset:
  - Stimulus: push in_err = 1 with 16'h2222.
  - Required: out_err = 1 only while 16'h2222 is at head.
  - Then assert rst = 0 with 1 entry held: next cycle count = 0, out_err = 0.
